// File: rtl/rx_sample_latch_if.sv
// rx_sample_latch_if: channel sample inputs, writer word select and status outputs of rx_sample_latch
//   chan_en/in_strb/in_i/in_q  per-channel enable, new-sample strobe and packed 24-bit I/Q samples
//   rd_i/rd_q                  writer word select (I-high, Q-high, else IQ-low)
//   clr_ovr                    one-cycle clear of overrun status
//   rxn_dout_A                 per-channel presented 16-bit word
//   rx_avail_A                 one-cycle pulse: new frame in holding registers
//   ovr_cnt/ovr_chan           saturating overrun count and sticky per-channel overrun flags
interface rx_sample_latch_if #(
    parameter int V_RX_CHANS = 4,
    parameter int IQ_W       = 24
);
    logic [V_RX_CHANS-1:0]      chan_en;
    logic [V_RX_CHANS-1:0]      in_strb;
    logic [V_RX_CHANS*IQ_W-1:0] in_i;
    logic [V_RX_CHANS*IQ_W-1:0] in_q;
    logic                       rd_i;
    logic                       rd_q;
    logic                       clr_ovr;
    logic [V_RX_CHANS*16-1:0]   rxn_dout_A;
    logic                       rx_avail_A;
    logic [7:0]                 ovr_cnt;
    logic [V_RX_CHANS-1:0]      ovr_chan;

    modport master (
        output chan_en, in_strb, in_i, in_q, rd_i, rd_q, clr_ovr,
        input  rxn_dout_A, rx_avail_A, ovr_cnt, ovr_chan
    );

    modport slave (
        input  chan_en, in_strb, in_i, in_q, rd_i, rd_q, clr_ovr,
        output rxn_dout_A, rx_avail_A, ovr_cnt, ovr_chan
    );
endinterface

// File: rtl/rx_sample_latch.sv
// rx_sample_latch: per-channel I/Q staging with an atomic frame swap into holding registers
//   adc_clk  sole clock
//   reset_n  asynchronous active-low reset
//   bus      rx_sample_latch_if.slave: samples/strobes/enables and writer word select in;
//            presented words, rx_avail_A frame pulse and overrun status out
module rx_sample_latch #(
    parameter int V_RX_CHANS  = 4,
    parameter int IQ_W        = 24,
    parameter int LOCK_CYCLES = 3*V_RX_CHANS+8
) (
    input logic              adc_clk,
    input logic              reset_n,
    rx_sample_latch_if.slave bus
);
    localparam int LW = $clog2(LOCK_CYCLES+1);

    logic [V_RX_CHANS-1:0][IQ_W-1:0] in_i, in_q, stg_i, stg_q, hld_i, hld_q;
    logic [V_RX_CHANS-1:0][15:0]     dout;
    logic [V_RX_CHANS-1:0]           pend, strb, ovr, ovr_chan;
    logic [LW-1:0]                   lock_cnt;
    logic [7:0]                      ovr_cnt;
    logic                            ready, swap, rx_avail;

    assign in_i  = bus.in_i;
    assign in_q  = bus.in_q;
    assign strb  = bus.in_strb & bus.chan_en;
    assign ready = &(pend | ~bus.chan_en);
    assign swap  = ready && lock_cnt == '0 && |bus.chan_en;
    // A re-strobe on the swap edge is the start of the next frame, not an overrun
    assign ovr   = strb & pend & {V_RX_CHANS{~swap}};

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_i    <= '0;
            stg_q    <= '0;
            hld_i    <= '0;
            hld_q    <= '0;
            pend     <= '0;
            lock_cnt <= '0;
            rx_avail <= 1'b0;
            ovr_cnt  <= '0;
            ovr_chan <= '0;
        end else begin
            for (int n = 0; n < V_RX_CHANS; n++) begin
                if (!bus.chan_en[n]) begin
                    stg_i[n] <= '0;
                    stg_q[n] <= '0;
                    hld_i[n] <= '0;
                    hld_q[n] <= '0;
                    pend[n]  <= 1'b0;
                end else begin
                    if (strb[n]) begin
                        stg_i[n] <= in_i[n];
                        stg_q[n] <= in_q[n];
                    end
                    if (swap) begin
                        hld_i[n] <= stg_i[n];
                        hld_q[n] <= stg_q[n];
                    end
                    pend[n] <= swap ? strb[n] : pend[n] | strb[n];
                end
            end
            rx_avail <= swap;
            // Loaded one short because the pulse cycle itself counts toward the lockout,
            // so the next swap can land exactly LOCK_CYCLES cycles after this pulse
            lock_cnt <= swap ? LW'(LOCK_CYCLES-1) : lock_cnt != '0 ? lock_cnt - LW'(1) : lock_cnt;
            if (bus.clr_ovr) begin
                ovr_cnt  <= {7'd0, |ovr};
                ovr_chan <= ovr;
            end else begin
                if (|ovr && ovr_cnt != 8'hFF)
                    ovr_cnt <= ovr_cnt + 8'd1;
                ovr_chan <= ovr_chan | ovr;
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int n = 0; n < V_RX_CHANS; n++)
            dout[n] = bus.rd_i ? hld_i[n][IQ_W-1:8] :
                      bus.rd_q ? hld_q[n][IQ_W-1:8] : {hld_i[n][7:0], hld_q[n][7:0]};
    end

    assign bus.rxn_dout_A = dout;
    assign bus.rx_avail_A = rx_avail;
    assign bus.ovr_cnt    = ovr_cnt;
    assign bus.ovr_chan   = ovr_chan;
endmodule
